alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, two-stage pipelined ALU: next generation of the 16-bit combinational ALU.
//  Same op set (rotate/shift group, add/and/or/xor group), invA/invB/Cin/sign controls, Zero/Ofl flags.
//  Adds valid/ready handshakes on input and output, full-throughput backpressure, and a sticky overflow status bit.
//  Sits between decode/issue and writeback in the pipelined datapath.
// PARAMETERS
//  N      16  operand/result width; power of two, >= 4
//  SHW    $clog2(N)  shift-count width (derived localparam); count = b_eff[SHW-1:0]
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    asynchronous, active-high reset
//  in_valid     in   1    operand bundle valid
//  in_ready     out  1    block accepts bundle this cycle
//  A, B         in   N    operands
//  Cin          in   1    adder carry-in
//  Op           in   3    operation select (encodings in alu_pkg)
//  invA, invB   in   1    invert A / B before any op
//  sign         in   1    1: signed overflow rule, 0: unsigned (carry-out)
//  out_valid    out  1    result valid
//  out_ready    in   1    consumer accepts result this cycle
//  Out          out  N    result
//  Zero         out  1    Out == 0
//  Ofl          out  1    overflow; only for Op==ADD, else 0
//  clr_sticky   in   1    clear sticky_ofl
//  sticky_ofl   out  1    set by any delivered result with Ofl=1
// BEHAVIOUR
//  - Reset (async): both stage valid bits 0, Out=0, Zero=0, Ofl=0, sticky_ofl=0; in-flight ops discarded.
//  - Ops: Op[2]=0 -> shifter on a_eff by count: 00 ROL, 01 SLL, 10 SRA, 11 SRL.
//         Op[2]=1 -> 00 ADD(a_eff+b_eff+Cin), 01 AND, 10 OR, 11 XOR. a_eff=invA?~A:A, b_eff likewise.
//  - Ofl for ADD: sign=0 -> carry-out; sign=1 -> a_eff[N-1]==b_eff[N-1] && sum[N-1]!=a_eff[N-1].
//  - Stage 1 (S1): registers a_eff, b_eff, Cin, Op, sign on input handshake (in_valid && in_ready).
//  - Stage 2 (S2): computes result/flags from S1, registers into Out/Zero/Ofl and out_valid.
//  - Latency 2 cycles from accepted input to out_valid; throughput 1 op/cycle with out_ready=1.
//  - Advance rule: s2_adv = !out_valid || out_ready; s1_adv = s2_adv; in_ready = !s1_valid || s1_adv.
//  - Backpressure: out_valid && !out_ready holds Out/Zero/Ofl stable; S1 holds; in_ready drops
//    only when both stages full. No bubble insertion, no op dropped or duplicated.
//  - Output handshake completes on out_valid && out_ready; if S1 empty at that edge, out_valid -> 0.
//  - sticky_ofl: set on output handshake with Ofl=1; cleared by clr_sticky; same-cycle set+clear -> set wins.
//  - Zero computed on final (post-saturation) result.
// CONFIGURATION
//  ALU_SAT_EN defined: ADD with Ofl=1 returns saturated value (sign=1: max/min signed by a_eff[N-1];
//    sign=0: all ones); Ofl and sticky still report the overflow.
//  ALU_SAT_EN undefined: ADD returns wrapped N-bit sum; no saturation logic present.
// STRUCTURE
//  alu_pkg: Op encodings (OP_ROL..OP_XOR as 3-bit constants), S1 bundle struct typedef.
//  Sub-module alu_shifter #(N): combinational log-stage barrel shifter (4 modes), instantiated in S2.
//  Adder, logic ops, flags, pipeline regs, handshake and sticky logic inline in alu_pipe.
// TESTING (N=16)
//  1. ADD A=16'h7FFF B=16'h0001 Cin=0 sign=1 -> 2 cycles later Out=16'h8000, Ofl=1, Zero=0
//     (ALU_SAT_EN: Out=16'h7FFF, Ofl=1); sticky_ofl=1 after handshake.
//  2. ADD unsigned A=16'hFFFF B=16'h0001 sign=0 -> Out=0, Zero=1, Ofl=1; AND same operands -> Ofl=0.
//  3. Shifts A=16'h8001 B=4: ROL->16'h0018, SLL->16'h0010, SRA->16'hF800, SRL->16'h0800.
//  4. Stream 8 ops back-to-back, out_ready=1 -> 8 results in order on consecutive cycles after 2-cycle fill.
//  5. out_ready=0 for 5 cycles while feeding -> in_ready drops after 2 accepts, Out stable, no loss/dup on release.
//  6. Assert rst mid-stream with 2 ops in flight -> outputs 0 immediately, no stale result after release;
//     clr_sticky coincident with overflow delivery -> sticky_ofl stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared definitions for the pipelined ALU: operation encodings,
//            shifter mode encodings and the stage-1 control bundle.
//  Ports   : none (package)
//  Config  : ALU_SAT_EN (consumed by alu_pipe, not referenced here)
//  Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Op[2]=0 selects the shifter group, Op[2]=1 the arithmetic/logic group.
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Shifter mode is simply Op[1:0] of the shifter group.
  localparam logic [1:0] SH_ROL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_SRL = 2'b11;

  // Width-independent part of the stage-1 bundle; operands are held
  // alongside it because their width depends on the module parameter.
  typedef struct packed {
    logic [2:0] op;
    logic       cin;
    logic       sign;
  } s1_ctrl_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
//  Module  : alu_shifter
//  Purpose : Combinational logarithmic barrel shifter, four modes
//            (rotate left, logical left, arithmetic right, logical right).
//  Ports   : data_i  [N-1:0]   value to shift
//            count_i [SHW-1:0] shift amount
//            mode_i  [1:0]     SH_ROL / SH_SLL / SH_SRA / SH_SRL
//            data_o  [N-1:0]   shifted value
//  Config  : none
//  Rev     : 1.0  initial release
// ============================================================================
module alu_shifter
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]         data_i,
  input  logic [$clog2(N)-1:0] count_i,
  input  logic [1:0]           mode_i,
  output logic [N-1:0]         data_o
);

  localparam int SHW = $clog2(N);

  // stg[k] is the value after the first k stages; stage k shifts by 2**k.
  logic [SHW:0][N-1:0] stg;

  assign stg[0] = data_i;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S = 1 << k;

    logic [N-1:0] w_rol;
    logic [N-1:0] w_sll;
    logic [N-1:0] w_sra;
    logic [N-1:0] w_srl;
    logic [N-1:0] w_sel;

    assign w_rol = {stg[k][N-1-S:0], stg[k][N-1:N-S]};
    assign w_sll = {stg[k][N-1-S:0], {S{1'b0}}};
    assign w_sra = {{S{stg[k][N-1]}}, stg[k][N-1:S]};
    assign w_srl = {{S{1'b0}}, stg[k][N-1:S]};

    always_comb begin
      w_sel = w_rol;
      case (mode_i)
        SH_ROL: w_sel = w_rol;
        SH_SLL: w_sel = w_sll;
        SH_SRA: w_sel = w_sra;
        SH_SRL: w_sel = w_srl;
      endcase
    end

    assign stg[k+1] = count_i[k] ? w_sel : stg[k];
  end

  assign data_o = stg[SHW];

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pipe
//  Purpose : Two-stage pipelined ALU with valid/ready handshakes on both
//            sides, full-throughput backpressure and a sticky overflow bit.
//            S1 registers the effective operands and controls, S2 computes
//            and registers the result and flags.
//  Ports   : clk, rst (async, active high)
//            in_valid/in_ready, A, B, Cin, Op, invA, invB, sign  - input side
//            out_valid/out_ready, Out, Zero, Ofl                 - output side
//            clr_sticky, sticky_ofl                              - status
//  Config  : ALU_SAT_EN - when defined, an overflowing ADD returns the
//            saturated value instead of the wrapped sum.
//  Rev     : 1.0  initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [2:0]   Op,
  input  logic         invA,
  input  logic         invB,
  input  logic         sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         Zero,
  output logic         Ofl,
  input  logic         clr_sticky,
  output logic         sticky_ofl
);

  localparam int SHW = $clog2(N);

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic         s1_valid_q;
  logic [N-1:0] s1_a_q;
  logic [N-1:0] s1_b_q;
  s1_ctrl_t     s1_ctrl_q;

  logic         out_valid_q;
  logic [N-1:0] out_q;
  logic         zero_q;
  logic         ofl_q;
  logic         sticky_q;

  // --------------------------------------------------------------------------
  // Handshake: S2 may move whenever its content is absent or being taken;
  // S1 moves with S2, so input stalls only when both stages are full.
  // --------------------------------------------------------------------------
  logic w_s2_adv;
  logic w_in_hs;
  logic w_out_hs;

  assign w_s2_adv = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || w_s2_adv;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid_q && out_ready;

  // --------------------------------------------------------------------------
  // Stage 1: capture inverted operands and controls
  // --------------------------------------------------------------------------
  s1_ctrl_t w_ctrl_in;

  assign w_ctrl_in.op   = Op;
  assign w_ctrl_in.cin  = Cin;
  assign w_ctrl_in.sign = sign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ctrl_q  <= '0;
    end else if (in_ready) begin
      // in_ready implies S1 is empty or draining into S2 this edge.
      s1_valid_q <= in_valid;
      if (w_in_hs) begin
        s1_a_q    <= invA ? ~A : A;
        s1_b_q    <= invB ? ~B : B;
        s1_ctrl_q <= w_ctrl_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: execute
  // --------------------------------------------------------------------------
  logic [N-1:0] w_shift;
  logic [N:0]   w_sum;
  logic         w_sofl;

  alu_shifter #(
    .N (N)
  ) u_shifter (
    .data_i  (s1_a_q),
    .count_i (s1_b_q[SHW-1:0]),
    .mode_i  (s1_ctrl_q.op[1:0]),
    .data_o  (w_shift)
  );

  assign w_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{N{1'b0}}, s1_ctrl_q.cin};
  // Signed overflow: operands agree in sign but the sum does not.
  assign w_sofl = (s1_a_q[N-1] == s1_b_q[N-1]) && (w_sum[N-1] != s1_a_q[N-1]);

  logic [N-1:0] res_d;
  logic         ofl_d;
  logic         zero_d;

  always_comb begin
    res_d = w_shift;
    ofl_d = 1'b0;
    case (s1_ctrl_q.op)
      OP_ROL, OP_SLL, OP_SRA, OP_SRL: res_d = w_shift;
      OP_ADD: begin
        res_d = w_sum[N-1:0];
        ofl_d = s1_ctrl_q.sign ? w_sofl : w_sum[N];
`ifdef ALU_SAT_EN
        if (ofl_d) begin
          if (s1_ctrl_q.sign) begin
            // Both operands share a_eff's sign, so it picks the clamp end.
            res_d = s1_a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          end else begin
            res_d = '1;
          end
        end
`endif
      end
      OP_AND: res_d = s1_a_q & s1_b_q;
      OP_OR:  res_d = s1_a_q | s1_b_q;
      OP_XOR: res_d = s1_a_q ^ s1_b_q;
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      ofl_q       <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q  <= res_d;
        zero_q <= zero_d;
        ofl_q  <= ofl_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow: a delivered overflow beats a simultaneous clear.
  // --------------------------------------------------------------------------
  logic sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (w_out_hs && ofl_q) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign Out        = out_q;
  assign Zero       = zero_q;
  assign Ofl        = ofl_q;
  assign sticky_ofl = sticky_q;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_pipe
//  Purpose : Self-checking bench for alu_pipe (N=16). A reference model
//            pushes expected results at input acceptance; a monitor pops
//            and compares them at each output handshake.
//  Config  : honours ALU_SAT_EN for the expected ADD results.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [2:0]   Op;
  logic         invA;
  logic         invB;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Out;
  logic         Zero;
  logic         Ofl;
  logic         clr_sticky;
  logic         sticky_ofl;

  int n_checks;
  int n_fail;
  int cyc;
  int hs_cnt;

  logic [17:0] sb[$];      // {zero, ofl, out}
  int          acc_cyc[$];
  int          hs_cyc[$];

  alu_pipe #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .Cin        (Cin),
    .Op         (Op),
    .invA       (invA),
    .invB       (invB),
    .sign       (sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Out        (Out),
    .Zero       (Zero),
    .Ofl        (Ofl),
    .clr_sticky (clr_sticky),
    .sticky_ofl (sticky_ofl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference model of one operation.
  function automatic logic [17:0] model(input logic [15:0] a_in, input logic [15:0] b_in,
                                        input logic ci, input logic [2:0] op,
                                        input logic ia, input logic ib, input logic sg);
    logic [15:0] a, b, r;
    logic [16:0] s;
    logic        o;
    int          c;
    a = ia ? ~a_in : a_in;
    b = ib ? ~b_in : b_in;
    c = int'(b[3:0]);
    o = 1'b0;
    r = 16'h0;
    case (op)
      OP_ROL: r = (a << c) | (a >> (16 - c));
      OP_SLL: r = a << c;
      OP_SRA: r = $signed(a) >>> c;
      OP_SRL: r = a >> c;
      OP_ADD: begin
        s = 17'(a) + 17'(b) + 17'(ci);
        r = s[15:0];
        o = sg ? ((a[15] == b[15]) && (r[15] != a[15])) : s[16];
`ifdef ALU_SAT_EN
        if (o) r = sg ? (a[15] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = a ^ b;
    endcase
    return {(r == 16'h0), o, r};
  endfunction

  // Scoreboard monitor: compare at every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [17:0] e;
      hs_cnt++;
      hs_cyc.push_back(cyc);
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got Out=%h with no result expected", Out);
      end else begin
        e = sb.pop_front();
        if ({Zero, Ofl, Out} !== e) begin
          n_fail++;
          $display("FAIL scoreboard_result: got Zero=%b Ofl=%b Out=%h, expected Zero=%b Ofl=%b Out=%h",
                   Zero, Ofl, Out, e[17], e[16], e[15:0]);
        end
      end
    end
  end

  // Drive one op and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [2:0] op, input logic ia, input logic ib, input logic sg);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    A = a; B = b; Cin = ci; Op = op; invA = ia; invB = ib; sign = sg;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, ci, op, ia, ib, sg));
        acc_cyc.push_back(cyc);
        done = 1;
      end else if (++n > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (at a negedge) until out_valid is seen.
  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid_timeout: out_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  // Wait for all expected results to be delivered, then check idle.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: pending=%0d out_valid=%b, required 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, Out, Zero, Ofl, sticky_ofl} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b Out=%h Zero=%b Ofl=%b sticky=%b, required all 0",
               out_valid, Out, Zero, Ofl, sticky_ofl);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_signed();
    logic [15:0] exp_out;
`ifdef ALU_SAT_EN
    exp_out = 16'h7FFF;
`else
    exp_out = 16'h8000;
`endif
    send(16'h7FFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
    wait_valid();
    n_checks++;
    if (Out !== exp_out || Ofl !== 1'b1 || Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_signed: Out=%h Ofl=%b Zero=%b, required %h 1 0", Out, Ofl, Zero, exp_out);
    end
    drain();
    n_checks++;
    if (sticky_ofl !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: sticky_ofl=%b, required 1", sticky_ofl);
    end
  endtask

  task automatic test_add_unsigned();
    send(16'hFFFF, 16'h0001, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    wait_valid();
    n_checks++;
`ifdef ALU_SAT_EN
    if (Out !== 16'hFFFF || Zero !== 1'b0 || Ofl !== 1'b1) begin
      n_fail++;
      $display("FAIL add_unsigned: Out=%h Zero=%b Ofl=%b, required FFFF 0 1", Out, Zero, Ofl);
    end
`else
    if (Out !== 16'h0000 || Zero !== 1'b1 || Ofl !== 1'b1) begin
      n_fail++;
      $display("FAIL add_unsigned: Out=%h Zero=%b Ofl=%b, required 0000 1 1", Out, Zero, Ofl);
    end
`endif
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, OP_AND, 1'b0, 1'b0, 1'b0);
    wait_valid();
    n_checks++;
    if (Out !== 16'h0001 || Zero !== 1'b0 || Ofl !== 1'b0) begin
      n_fail++;
      $display("FAIL and_no_ofl: Out=%h Zero=%b Ofl=%b, required 0001 0 0", Out, Zero, Ofl);
    end
    drain();
  endtask

  task automatic test_shift();
    logic [2:0]  ops[4];
    logic [15:0] exp[4];
    ops = '{OP_ROL, OP_SLL, OP_SRA, OP_SRL};
    exp = '{16'h0018, 16'h0010, 16'hF800, 16'h0800};
    for (int i = 0; i < 4; i++) begin
      send(16'h8001, 16'h0004, 1'b0, ops[i], 1'b0, 1'b0, 1'b0);
      wait_valid();
      n_checks++;
      if (Out !== exp[i] || Ofl !== 1'b0) begin
        n_fail++;
        $display("FAIL shift_op%0d: Out=%h Ofl=%b, required %h 0", i, Out, Ofl, exp[i]);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    acc_cyc.delete();
    hs_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();
    n_checks++;
    if (hs_cyc.size() != 8 || acc_cyc.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: results=%0d accepts=%0d, required 8 and 8", hs_cyc.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (hs_cyc[i] != acc_cyc[0] + 2 + i || acc_cyc[i] != acc_cyc[0] + i) begin
          n_fail++;
          $display("FAIL b2b_timing%0d: result cycle=%0d accept cycle=%0d, required %0d and %0d",
                   i, hs_cyc[i], acc_cyc[i], acc_cyc[0] + 2 + i, acc_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va[6], vb[6];
    logic [2:0]  vop[6];
    logic [15:0] held;
    bit          held_set;
    int          idx, acc, hs0;
    logic        last_rdy;
    for (int i = 0; i < 6; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vop[i] = 3'($urandom);
    end
    held = '0; held_set = 0; idx = 0; acc = 0; last_rdy = 1'b1;
    hs0 = hs_cnt;
    out_ready = 1'b0;
    A = va[0]; B = vb[0]; Op = vop[0]; Cin = 1'b0; invA = 1'b0; invB = 1'b0; sign = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      last_rdy = in_ready;
      if (in_ready) begin
        sb.push_back(model(va[idx], vb[idx], 1'b0, vop[idx], 1'b0, 1'b0, 1'b1));
        idx++;
        acc++;
      end
      if (out_valid) begin
        if (!held_set) begin
          held = Out;
          held_set = 1;
        end else begin
          n_checks++;
          if (Out !== held) begin
            n_fail++;
            $display("FAIL bp_stable: Out=%h, required held %h", Out, held);
          end
        end
      end
      @(posedge clk);
      #1;
      A = va[idx]; B = vb[idx]; Op = vop[idx];
    end
    n_checks++;
    if (acc != 2 || last_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accepts: accepts=%0d in_ready=%b, required 2 and 0", acc, last_rdy);
    end
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) begin
      send(va[i], vb[i], 1'b0, vop[i], 1'b0, 1'b0, 1'b1);
    end
    drain();
    n_checks++;
    if (hs_cnt - hs0 != 6) begin
      n_fail++;
      $display("FAIL bp_total: delivered=%0d, required 6", hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_midstream();
    int hs0;
    out_ready = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
    send(16'h00F0, 16'h0F0F, 1'b0, OP_OR, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, Out, Zero, Ofl, sticky_ofl} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: out_valid=%b Out=%h Zero=%b Ofl=%b sticky=%b, required all 0",
               out_valid, Out, Zero, Ofl, sticky_ofl);
    end
    sb.delete();
    hs0 = hs_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (hs_cnt != hs0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: delivered=%0d out_valid=%b, required 0 and 0", hs_cnt - hs0, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sticky_clear();
    out_ready = 1'b1;
    send(16'h8000, 16'h8000, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
    wait_valid();
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_ofl !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: sticky_ofl=%b, required 1", sticky_ofl);
    end
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_ofl !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear: sticky_ofl=%b, required 0", sticky_ofl);
    end
    drain();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; hs_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Op = OP_ADD;
    invA = 1'b0; invB = 1'b0; sign = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    test_reset();
    test_add_signed();
    test_add_unsigned();
    test_shift();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_sticky_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_pipe
`default_nettype wire
